// File: rtl/issue_buffer_if.sv
// Fetch-to-issue handshake bundle for issue_buffer; the buffer takes the master modport.
// Optional ISSUE_BUF_PERF_EN adds the performance counter outputs.
`ifndef CTRL_BUS
`define CTRL_BUS [15:0]
`endif

interface issue_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                flush_i;
  logic                wr0_valid_i;
  logic                wr1_valid_i;
  logic [31:0]         wr0_inst_i;
  logic [31:0]         wr1_inst_i;
  logic `CTRL_BUS      wr0_ctrl_i;
  logic `CTRL_BUS      wr1_ctrl_i;
  logic                wr0_pred_i;
  logic                wr1_pred_i;
  logic [31:0]         wr0_tgt_i;
  logic [31:0]         wr1_tgt_i;
  logic                ready_o;
  logic                issue_stall_i;
  logic                issue1_stall_i;
  logic [31:0]         inst0_o;
  logic [31:0]         inst1_o;
  logic `CTRL_BUS      ctrl0_o;
  logic `CTRL_BUS      ctrl1_o;
  logic                pred_0_o;
  logic                pred_1_o;
  logic [31:0]         pred_tgt_0_o;
  logic [31:0]         pred_tgt_1_o;
  logic                valid0_o;
  logic                valid1_o;
  logic [CNT_W-1:0]    count_o;
`ifdef ISSUE_BUF_PERF_EN
  logic [31:0]         empty_cycles_o;
  logic [31:0]         partial_issue_o;
`endif

  modport master (
`ifdef ISSUE_BUF_PERF_EN
    output empty_cycles_o, partial_issue_o,
`endif
    input  flush_i, wr0_valid_i, wr1_valid_i, wr0_inst_i, wr1_inst_i,
           wr0_ctrl_i, wr1_ctrl_i, wr0_pred_i, wr1_pred_i, wr0_tgt_i, wr1_tgt_i,
           issue_stall_i, issue1_stall_i,
    output ready_o, inst0_o, inst1_o, ctrl0_o, ctrl1_o, pred_0_o, pred_1_o,
           pred_tgt_0_o, pred_tgt_1_o, valid0_o, valid1_o, count_o
  );

  modport slave (
`ifdef ISSUE_BUF_PERF_EN
    input  empty_cycles_o, partial_issue_o,
`endif
    output flush_i, wr0_valid_i, wr1_valid_i, wr0_inst_i, wr1_inst_i,
           wr0_ctrl_i, wr1_ctrl_i, wr0_pred_i, wr1_pred_i, wr0_tgt_i, wr1_tgt_i,
           issue_stall_i, issue1_stall_i,
    input  ready_o, inst0_o, inst1_o, ctrl0_o, ctrl1_o, pred_0_o, pred_1_o,
           pred_tgt_0_o, pred_tgt_1_o, valid0_o, valid1_o, count_o
  );
endinterface

// File: rtl/issue_buffer.sv
// Dual-write / dual-read instruction queue feeding the dual-issue stage.
// Define ISSUE_BUF_PERF_EN to add saturating empty-cycle and partial-issue counters.
`ifndef CTRL_BUS
`define CTRL_BUS [15:0]
`endif

module issue_buffer #(
  parameter int DEPTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  issue_buffer_if.master   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]    inst;
    logic `CTRL_BUS ctrl;
    logic           pred;
    logic [31:0]    tgt;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           ent0, ent1, wr0_ent, wr1_ent;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       nrd, nwr;
  logic             valid0, valid1, ready;

  assign valid0    = (count_q != '0);
  assign valid1    = (count_q >= CNT_W'(2));
  assign ready     = (count_q <= CNT_W'(DEPTH - 2));
  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  assign wr0_ent = '{inst: bus.wr0_inst_i, ctrl: bus.wr0_ctrl_i,
                     pred: bus.wr0_pred_i, tgt: bus.wr0_tgt_i};
  assign wr1_ent = '{inst: bus.wr1_inst_i, ctrl: bus.wr1_ctrl_i,
                     pred: bus.wr1_pred_i, tgt: bus.wr1_tgt_i};

  always_comb begin
    nrd = 2'd0;
    if (valid0 && !bus.issue_stall_i)
      nrd = (valid1 && !bus.issue1_stall_i) ? 2'd2 : 2'd1;
    nwr = 2'd0;
    if (ready && bus.wr0_valid_i)
      nwr = bus.wr1_valid_i ? 2'd2 : 2'd1;
    rd_ptr_d = rd_ptr_q + PTR_W'(nrd);
    wr_ptr_d = wr_ptr_q + PTR_W'(nwr);
    count_d  = count_q + CNT_W'(nwr) - CNT_W'(nrd);
    // A redirect discards everything, including this cycle's traffic.
    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; pointers and count decide what is live.
  always_ff @(posedge clock_i) begin
    if (!reset_i && !bus.flush_i) begin
      if (nwr != 2'd0) mem[wr_ptr_q]  <= wr0_ent;
      if (nwr == 2'd2) mem[wr_ptr_p1] <= wr1_ent;
    end
  end

  assign ent0 = mem[rd_ptr_q];
  assign ent1 = mem[rd_ptr_p1];

  assign bus.inst0_o      = valid0 ? ent0.inst : NOP;
  assign bus.inst1_o      = valid1 ? ent1.inst : NOP;
  assign bus.ctrl0_o      = valid0 ? ent0.ctrl : '0;
  assign bus.ctrl1_o      = valid1 ? ent1.ctrl : '0;
  assign bus.pred_0_o     = valid0 & ent0.pred;
  assign bus.pred_1_o     = valid1 & ent1.pred;
  assign bus.pred_tgt_0_o = valid0 ? ent0.tgt : 32'd0;
  assign bus.pred_tgt_1_o = valid1 ? ent1.tgt : 32'd0;
  assign bus.valid0_o     = valid0;
  assign bus.valid1_o     = valid1;
  assign bus.ready_o      = ready;
  assign bus.count_o      = count_q;

`ifdef ISSUE_BUF_PERF_EN
  logic [31:0] empty_cycles_q, partial_issue_q;

  // Flush deliberately leaves these running; only reset clears them.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      empty_cycles_q  <= '0;
      partial_issue_q <= '0;
    end else begin
      if (!valid0 && empty_cycles_q != '1)
        empty_cycles_q <= empty_cycles_q + 32'd1;
      if (nrd == 2'd1 && valid1 && partial_issue_q != '1)
        partial_issue_q <= partial_issue_q + 32'd1;
    end
  end

  assign bus.empty_cycles_o  = empty_cycles_q;
  assign bus.partial_issue_o = partial_issue_q;
`endif

endmodule

// File: tb/tb_issue_buffer.sv
// Directed checks for issue_buffer: reset, pair write/issue, partial issue, full, flush, ordered stream.
`ifndef CTRL_BUS
`define CTRL_BUS [15:0]
`endif

module tb_issue_buffer;
  logic clk = 1'b0;
  logic srst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  issue_buffer_if #(.DEPTH(8)) bus ();

  issue_buffer #(.DEPTH(8)) dut (
    .clock_i (clk),
    .reset_i (srst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pair(input logic v0, input logic v1,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic p1, input logic [31:0] t1);
    bus.wr0_valid_i = v0;
    bus.wr1_valid_i = v1;
    bus.wr0_inst_i  = i0;
    bus.wr1_inst_i  = i1;
    bus.wr0_ctrl_i  = i0[15:0];
    bus.wr1_ctrl_i  = i1[15:0];
    bus.wr0_pred_i  = 1'b0;
    bus.wr1_pred_i  = p1;
    bus.wr0_tgt_i   = 32'd0;
    bus.wr1_tgt_i   = t1;
  endtask

  initial begin
    int nxt_w, nxt_r, mcnt, nrd_m, nwr_m, partial_m;
    logic stall, s1, want;

    srst = 1'b1;
    bus.flush_i = 1'b0;
    bus.issue_stall_i = 1'b0;
    bus.issue1_stall_i = 1'b0;
    wr_pair(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    // 1: reset state
    repeat (2) step();
    srst = 1'b0;
    chk("rst_valid0", bus.valid0_o, 0);
    chk("rst_valid1", bus.valid1_o, 0);
    chk("rst_inst0", bus.inst0_o, 32'h13);
    chk("rst_inst1", bus.inst1_o, 32'h13);
    chk("rst_ctrl0", bus.ctrl0_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_count", bus.count_o, 0);

    // 2: pair write then full issue
    wr_pair(1'b1, 1'b1, 32'h0050_0093, 32'h0010_8133, 1'b1, 32'h100);
    step();
    wr_pair(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("pair_inst0", bus.inst0_o, 32'h0050_0093);
    chk("pair_inst1", bus.inst1_o, 32'h0010_8133);
    chk("pair_pred1", bus.pred_1_o, 1);
    chk("pair_tgt1", bus.pred_tgt_1_o, 32'h100);
    chk("pair_pred0", bus.pred_0_o, 0);
    chk("pair_ctrl1", bus.ctrl1_o, 16'h8133);
    chk("pair_count", bus.count_o, 2);
    step();
    chk("drain_count", bus.count_o, 0);
    chk("drain_inst0", bus.inst0_o, 32'h13);

    // 3: partial issue re-presents the held instruction as slot0
    wr_pair(1'b1, 1'b1, 32'hA, 32'hB, 1'b0, 32'd0);
    step();
    wr_pair(1'b1, 1'b0, 32'hC, 32'd0, 1'b0, 32'd0);
    bus.issue_stall_i = 1'b1;
    step();
    chk("abc_count", bus.count_o, 3);
    wr_pair(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    bus.issue_stall_i = 1'b0;
    bus.issue1_stall_i = 1'b1;
    step();
    chk("part_inst0", bus.inst0_o, 32'hB);
    chk("part_inst1", bus.inst1_o, 32'hC);
    chk("part_count", bus.count_o, 2);
    bus.issue1_stall_i = 1'b0;
    step();
    chk("part_drain", bus.count_o, 0);

    // 4: fill to full under stall; fifth pair dropped
    bus.issue_stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_pair(1'b1, 1'b1, 32'h10 + 32'(2*k), 32'h11 + 32'(2*k), 1'b0, 32'd0);
      step();
    end
    chk("full_count", bus.count_o, 8);
    chk("full_ready", bus.ready_o, 0);
    wr_pair(1'b1, 1'b1, 32'h99, 32'h9A, 1'b0, 32'd0);
    step();
    chk("drop_count", bus.count_o, 8);
    chk("drop_inst0", bus.inst0_o, 32'h10);
    wr_pair(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    bus.issue_stall_i = 1'b0;
    bus.issue1_stall_i = 1'b1;
    step();
    chk("rel1_count", bus.count_o, 7);
    chk("rel1_ready", bus.ready_o, 0);
    chk("rel1_inst0", bus.inst0_o, 32'h11);
    chk("rel1_inst1", bus.inst1_o, 32'h12);

    // 5: flush at count 5 with a concurrent write
    bus.issue1_stall_i = 1'b0;
    step();
    chk("pre_flush_count", bus.count_o, 5);
    chk("pre_flush_inst0", bus.inst0_o, 32'h13);
    bus.flush_i = 1'b1;
    wr_pair(1'b1, 1'b1, 32'h77, 32'h78, 1'b0, 32'd0);
    step();
    bus.flush_i = 1'b0;
    wr_pair(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("flush_count", bus.count_o, 0);
    chk("flush_valid0", bus.valid0_o, 0);
    chk("flush_ready", bus.ready_o, 1);

    // 6: ordered stream of 20 pairs with random stalls
    nxt_w = 0; nxt_r = 0; mcnt = 0; partial_m = 2;
    for (int cyc = 0; cyc < 600 && nxt_r < 40; cyc++) begin
      chk("s_count", bus.count_o, mcnt);
      if (mcnt >= 1) begin
        chk("s_inst0", bus.inst0_o, nxt_r);
        chk("s_pred0", bus.pred_0_o, nxt_r % 2);
        chk("s_tgt0", bus.pred_tgt_0_o, 32'h1000 + 32'(4*nxt_r));
      end
      if (mcnt >= 2) begin
        chk("s_inst1", bus.inst1_o, nxt_r + 1);
        chk("s_tgt1", bus.pred_tgt_1_o, 32'h1000 + 32'(4*(nxt_r+1)));
      end
      stall = ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 2) == 0);
      want  = (nxt_w < 40) && ($urandom_range(0, 4) != 0);
      nrd_m = (mcnt == 0 || stall) ? 0 : (mcnt >= 2 && !s1) ? 2 : 1;
      if (nrd_m == 1 && mcnt >= 2) partial_m++;
      nwr_m = (want && mcnt <= 6) ? 2 : 0;
      bus.issue_stall_i  = stall;
      bus.issue1_stall_i = s1;
      bus.wr0_valid_i = want;
      bus.wr1_valid_i = want;
      bus.wr0_inst_i  = 32'(nxt_w);
      bus.wr1_inst_i  = 32'(nxt_w + 1);
      bus.wr0_ctrl_i  = 16'(nxt_w);
      bus.wr1_ctrl_i  = 16'(nxt_w + 1);
      bus.wr0_pred_i  = 1'b0;
      bus.wr1_pred_i  = 1'b1;
      bus.wr0_tgt_i   = 32'h1000 + 32'(4*nxt_w);
      bus.wr1_tgt_i   = 32'h1000 + 32'(4*(nxt_w+1));
      step();
      nxt_r += nrd_m;
      nxt_w += nwr_m;
      mcnt  += nwr_m - nrd_m;
    end
    wr_pair(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    bus.issue_stall_i = 1'b0;
    bus.issue1_stall_i = 1'b0;
    chk("s_drained", 64'(nxt_r), 40);
    chk("s_end_count", bus.count_o, 0);
`ifdef ISSUE_BUF_PERF_EN
    chk("s_partial", bus.partial_issue_o, 64'(partial_m));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
